// File: rtl/alu_checker.sv
// Checks an external ALU: drives captured operands, waits SETTLE_CYCLES, compares dut_out to a reference result.
// Accept-to-res_valid latency SETTLE_CYCLES+1; in_ready only in IDLE, requests while busy are dropped.
module alu_checker #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [2:0]  in_op,
    output logic [31:0] dut_a,
    output logic [31:0] dut_b,
    input  logic [31:0] dut_out,
    output logic        res_valid,
    output logic        res_match,
    output logic [15:0] chk_count,
    output logic [15:0] err_count,
    output logic [31:0] fail_exp,
    output logic [31:0] fail_got,
    output logic        fail_seen
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        COMPARE = 2'd2,
        REPORT  = 2'd3
    } state_t;

    localparam logic [3:0]  SETTLE_INIT = 4'(SETTLE_CYCLES - 1);
    localparam logic [15:0] CNT_MAX     = 16'hFFFF;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [2:0]  op_q, op_d;
    logic        match_q, match_d;
    logic [31:0] exp_q, exp_d;
    logic [31:0] got_q, got_d;
    logic [15:0] chk_count_q, chk_count_d;
    logic [15:0] err_count_q, err_count_d;
    logic [31:0] fail_exp_q, fail_exp_d;
    logic [31:0] fail_got_q, fail_got_d;
    logic        fail_seen_q, fail_seen_d;

    logic [31:0] exp_calc;
    logic        op_legal;

    // Illegal opcodes expect zero and can never match.
    always_comb begin
        exp_calc = '0;
        op_legal = 1'b1;
        case (op_q)
            3'b000:  exp_calc = a_q + b_q;
            3'b001:  exp_calc = a_q - b_q;
            3'b010:  exp_calc = a_q & b_q;
            3'b011:  exp_calc = a_q | b_q;
            3'b100:  exp_calc = a_q ^ b_q;
            default: op_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        match_d     = match_q;
        exp_d       = exp_q;
        got_d       = got_q;
        chk_count_d = chk_count_q;
        err_count_d = err_count_q;
        fail_exp_d  = fail_exp_q;
        fail_got_d  = fail_got_q;
        fail_seen_d = fail_seen_q;
        in_ready    = 1'b0;
        res_valid   = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    op_d    = in_op;
                    cnt_d   = SETTLE_INIT;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = COMPARE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            COMPARE: begin
                exp_d   = exp_calc;
                got_d   = dut_out;
                match_d = op_legal && (dut_out == exp_calc);
                state_d = REPORT;
            end
            REPORT: begin
                res_valid = 1'b1;
                state_d   = IDLE;
                if (chk_count_q != CNT_MAX) begin
                    chk_count_d = chk_count_q + 16'd1;
                end
                if (!match_q) begin
                    if (err_count_q != CNT_MAX) begin
                        err_count_d = err_count_q + 16'd1;
                    end
                    if (!fail_seen_q) begin
                        fail_exp_d  = exp_q;
                        fail_got_d  = got_q;
                        fail_seen_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear overrides any update made by a coincident REPORT.
        if (clr) begin
            chk_count_d = '0;
            err_count_d = '0;
            fail_exp_d  = '0;
            fail_got_d  = '0;
            fail_seen_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            match_q     <= 1'b0;
            exp_q       <= '0;
            got_q       <= '0;
            chk_count_q <= '0;
            err_count_q <= '0;
            fail_exp_q  <= '0;
            fail_got_q  <= '0;
            fail_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            match_q     <= match_d;
            exp_q       <= exp_d;
            got_q       <= got_d;
            chk_count_q <= chk_count_d;
            err_count_q <= err_count_d;
            fail_exp_q  <= fail_exp_d;
            fail_got_q  <= fail_got_d;
            fail_seen_q <= fail_seen_d;
        end
    end

    assign dut_a     = a_q;
    assign dut_b     = b_q;
    assign res_match = match_q;
    assign chk_count = chk_count_q;
    assign err_count = err_count_q;
    assign fail_exp  = fail_exp_q;
    assign fail_got  = fail_got_q;
    assign fail_seen = fail_seen_q;

endmodule

// File: tb/tb_alu_checker.sv
// Directed bench for alu_checker: vector table for the compare function plus hand sequences for reset/clear/saturation.
module tb_alu_checker;

    localparam int S   = 2;
    localparam int LAT = S + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [2:0]  in_op = '0;
    logic [31:0] dut_a, dut_b;
    logic [31:0] dut_out = '0;
    logic        res_valid, res_match;
    logic [15:0] chk_count, err_count;
    logic [31:0] fail_exp, fail_got;
    logic        fail_seen;

    int n_cmp = 0;
    int n_bad = 0;

    alu_checker #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .dut_a(dut_a), .dut_b(dut_b), .dut_out(dut_out),
        .res_valid(res_valid), .res_match(res_match),
        .chk_count(chk_count), .err_count(err_count),
        .fail_exp(fail_exp), .fail_got(fail_got), .fail_seen(fail_seen)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] dout;
        logic        match;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns edges until res_valid (-1 on timeout); also flags any in_ready seen while busy.
    task automatic wait_res(output int lat, output logic m, output logic rdy_seen);
        lat = -1;
        m = 1'b0;
        rdy_seen = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (lat < 0) begin
                tick();
                if (res_valid) begin
                    lat = k;
                    m = res_match;
                end else if (in_ready) begin
                    rdy_seen = 1'b1;
                end
            end
        end
    endtask

    task automatic do_check(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                            input logic [31:0] dout, input bit hold, output logic m, output int lat,
                            output logic rdy_seen);
        in_a = a;
        in_b = b;
        in_op = op;
        dut_out = dout;
        in_valid = 1'b1;
        tick();
        if (!hold) in_valid = 1'b0;
        wait_res(lat, m, rdy_seen);
        in_valid = 1'b0;
        tick();
    endtask

    vec_t vecs[6];
    logic m;
    logic rdy;
    int   lat;
    bit   seen_rv;

    initial begin
        vecs[0] = '{32'd2,        32'd2,        3'b000, 32'd4,          1'b1};
        vecs[1] = '{32'hFFFFFFFF, 32'd1,        3'b000, 32'd0,          1'b1};
        vecs[2] = '{32'd0,        32'd1,        3'b001, 32'hFFFFFFFF,   1'b1};
        vecs[3] = '{32'h0000F0F0, 32'h0000FF00, 3'b100, 32'h00000FF0,   1'b1};
        vecs[4] = '{32'd5,        32'd7,        3'b001, 32'hFFFFFFFE,   1'b1};
        vecs[5] = '{32'd1,        32'd1,        3'b000, 32'd3,          1'b0};

        // Reset state
        tick();
        tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_res_match", {31'd0, res_match}, 32'd0);
        check("rst_chk_count", {16'd0, chk_count}, 32'd0);
        check("rst_err_count", {16'd0, err_count}, 32'd0);
        check("rst_fail_seen", {31'd0, fail_seen}, 32'd0);
        check("rst_dut_a", dut_a, 32'd0);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) begin
            do_check(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].dout, 1'b0, m, lat, rdy);
            check($sformatf("vec%0d_latency", i), lat, LAT);
            check($sformatf("vec%0d_match", i), {31'd0, m}, {31'd0, vecs[i].match});
            check($sformatf("vec%0d_dut_a", i), dut_a, vecs[i].a);
            check($sformatf("vec%0d_dut_b", i), dut_b, vecs[i].b);
        end
        check("tbl_chk_count", {16'd0, chk_count}, 32'd6);
        check("tbl_err_count", {16'd0, err_count}, 32'd1);
        check("tbl_fail_exp", fail_exp, 32'd2);
        check("tbl_fail_got", fail_got, 32'd3);
        check("tbl_fail_seen", {31'd0, fail_seen}, 32'd1);

        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_chk_count", {16'd0, chk_count}, 32'd0);
        check("clr_err_count", {16'd0, err_count}, 32'd0);
        check("clr_fail_seen", {31'd0, fail_seen}, 32'd0);
        check("clr_fail_exp", fail_exp, 32'd0);

        // First mismatch is kept, second is counted only
        do_check(32'd5, 32'd3, 3'b010, 32'd7, 1'b0, m, lat, rdy);
        check("and_match", {31'd0, m}, 32'd0);
        do_check(32'd5, 32'd3, 3'b011, 32'd0, 1'b0, m, lat, rdy);
        check("or_match", {31'd0, m}, 32'd0);
        check("two_err_count", {16'd0, err_count}, 32'd2);
        check("two_chk_count", {16'd0, chk_count}, 32'd2);
        check("two_fail_exp", fail_exp, 32'd1);
        check("two_fail_got", fail_got, 32'd7);
        check("two_fail_seen", {31'd0, fail_seen}, 32'd1);

        // Illegal op with in_valid held through the whole check
        do_check(32'd0, 32'd0, 3'b110, 32'd0, 1'b1, m, lat, rdy);
        check("illegal_latency", lat, LAT);
        check("illegal_match", {31'd0, m}, 32'd0);
        check("illegal_rdy_busy", {31'd0, rdy}, 32'd0);
        check("illegal_err_count", {16'd0, err_count}, 32'd3);
        check("illegal_chk_count", {16'd0, chk_count}, 32'd3);
        check("illegal_fail_exp", fail_exp, 32'd1);

        // Asynchronous reset during SETTLE aborts the check
        in_a = 32'h1234;
        in_b = 32'h1;
        in_op = 3'b000;
        dut_out = 32'h1235;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        check("arst_res_valid", {31'd0, res_valid}, 32'd0);
        tick();
        rst = 1'b0;
        seen_rv = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (res_valid) seen_rv = 1'b1;
        end
        check("arst_no_res_valid", {31'd0, seen_rv}, 32'd0);
        check("arst_chk_count", {16'd0, chk_count}, 32'd0);
        check("arst_err_count", {16'd0, err_count}, 32'd0);
        check("arst_dut_a", dut_a, 32'd0);
        check("arst_fail_seen", {31'd0, fail_seen}, 32'd0);

        // Clear coincident with REPORT of a mismatch
        do_check(32'd9, 32'd4, 3'b001, 32'd0, 1'b0, m, lat, rdy);
        check("pre_clr_err_count", {16'd0, err_count}, 32'd1);
        in_a = 32'd3;
        in_b = 32'd3;
        in_op = 3'b100;
        dut_out = 32'd1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_res(lat, m, rdy);
        check("clrrep_latency", lat, LAT);
        check("clrrep_match", {31'd0, m}, 32'd0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clrrep_chk_count", {16'd0, chk_count}, 32'd0);
        check("clrrep_err_count", {16'd0, err_count}, 32'd0);
        check("clrrep_fail_seen", {31'd0, fail_seen}, 32'd0);
        check("clrrep_fail_got", fail_got, 32'd0);
        check("clrrep_in_ready", {31'd0, in_ready}, 32'd1);

        // Saturation: preload both counters at the ceiling
        force dut.chk_count_q = 16'hFFFF;
        force dut.err_count_q = 16'hFFFF;
        tick();
        tick();
        release dut.chk_count_q;
        release dut.err_count_q;
        tick();
        check("sat_preload_chk", {16'd0, chk_count}, 32'h0000FFFF);
        do_check(32'd1, 32'd1, 3'b000, 32'd5, 1'b0, m, lat, rdy);
        check("sat_mis_chk_count", {16'd0, chk_count}, 32'h0000FFFF);
        check("sat_mis_err_count", {16'd0, err_count}, 32'h0000FFFF);
        do_check(32'd1, 32'd1, 3'b000, 32'd2, 1'b0, m, lat, rdy);
        check("sat_ok_match", {31'd0, m}, 32'd1);
        check("sat_ok_chk_count", {16'd0, chk_count}, 32'h0000FFFF);
        check("sat_ok_err_count", {16'd0, err_count}, 32'h0000FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_checker.md
ALU_CHECKER -- requirements
Module: alu_checker

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, meaning cycles the operands are held on dut_a/dut_b before dut_out is sampled (legal range 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 clr  input  1  synchronous clear of counters and failure record.
REQ-005 in_valid  input  1  operand request valid.
REQ-006 in_ready  output  1  checker able to accept a request.
REQ-007 in_a  input  32  operand A.
REQ-008 in_b  input  32  operand B.
REQ-009 in_op  input  3  operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101-111 illegal.
REQ-010 dut_a  output  32  operand A driven to the ALU under test.
REQ-011 dut_b  output  32  operand B driven to the ALU under test.
REQ-012 dut_out  input  32  ALU result returned from the ALU under test.
REQ-013 res_valid  output  1  one-cycle pulse, comparison result available.
REQ-014 res_match  output  1  1 = dut_out equalled expected; valid with res_valid.
REQ-015 chk_count  output  16  number of completed checks.
REQ-016 err_count  output  16  number of mismatching checks.
REQ-017 fail_exp  output  32  expected value of first mismatch since reset/clr.
REQ-018 fail_got  output  32  dut_out value of first mismatch since reset/clr.
REQ-019 fail_seen  output  1  1 = fail_exp/fail_got hold a recorded mismatch.

Function
REQ-020 FSM states IDLE, SETTLE, COMPARE, REPORT; only IDLE asserts in_ready.
REQ-021 IDLE: on in_valid & in_ready, capture in_a, in_b, in_op into registers; go SETTLE with settle counter = SETTLE_CYCLES-1; in_valid while not ready is ignored, no queuing.
REQ-022 dut_a/dut_b driven from captured registers; unchanged from capture until next accept.
REQ-023 SETTLE: decrement counter each cycle; at 0 go COMPARE; total cycles from accept edge to COMPARE = SETTLE_CYCLES.
REQ-024 COMPARE: sample dut_out; expected = captured op applied to captured operands, 32-bit, modulo 2^32 (ADD/SUB wrap, no carry/overflow kept); go REPORT.
REQ-025 Illegal op: expected = 0, match forced 0 regardless of dut_out.
REQ-026 REPORT: res_valid=1 for exactly one cycle, res_match reflects COMPARE result; chk_count += 1; err_count += 1 on mismatch; return IDLE next cycle.
REQ-027 Latency: accept edge to res_valid = SETTLE_CYCLES + 1 cycles; max throughput one check per SETTLE_CYCLES + 2 cycles.
REQ-028 chk_count, err_count saturate at 16'hFFFF; no wrap.
REQ-029 First mismatch only: when fail_seen=0 and mismatch reported, load fail_exp/fail_got and set fail_seen; later mismatches do not overwrite.
REQ-030 clr in any state: zero chk_count, err_count, fail_exp, fail_got, fail_seen; FSM unaffected; clr coincident with REPORT wins (counters end at 0, fail record stays clear).
REQ-031 res_match holds last value outside res_valid; consumers ignore it then.

Reset
REQ-032 rst asserted: immediately FSM=IDLE, in_ready=1 after release, res_valid=0, res_match=0, all counters, fail_* registers, dut_a, dut_b, captured op = 0.
REQ-033 rst mid-check (SETTLE/COMPARE/REPORT) aborts the check; no count update, no res_valid after release.

Verification
REQ-034 SETTLE_CYCLES=2, ADD a=2 b=2, dut_out=4 -> res_valid 3 cycles after accept, res_match=1, chk_count=1, err_count=0.
REQ-035 ADD a=32'hFFFFFFFF b=1, dut_out=0 -> match=1 (wrap); SUB a=0 b=1, dut_out=32'hFFFFFFFF -> match=1.
REQ-036 AND 5/3 dut_out=7, then OR 5/3 dut_out=0 -> err_count=2, fail_exp=1, fail_got=7, fail_seen=1 (second mismatch not recorded).
REQ-037 in_op=3'b110, dut_out=0 -> res_match=0, err_count+1; in_valid held high during SETTLE -> no second accept until IDLE.
REQ-038 rst pulsed during SETTLE -> no res_valid, all counters 0; clr during REPORT of a mismatch -> chk_count=0, err_count=0, fail_seen=0.
REQ-039 Preload counters to 16'hFFFF via 65535 mismatching checks -> further check leaves both at 16'hFFFF.
